// File: rtl/us_delay_sched_pkg.sv
// Shared types and defaults for the microsecond delay scheduler.
// Holds the FSM state encoding and default channel/counter sizing.
package us_delay_sched_pkg;

  localparam int NREQ_DEF = 4;
  localparam int DW_DEF   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/us_delay_sched_rr_pick.sv
// Round-robin selector: first set request at or after ptr, wrapping.
// Purely combinational so other arbiters can reuse it directly.
module rr_pick
  import us_delay_sched_pkg::*;
#(
  parameter int N  = NREQ_DEF,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Scan from farthest to nearest so the nearest hit is written last.
  always_comb begin
    int j;
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        valid = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/us_delay_sched.sv
// Shared microsecond delay scheduler: one down-counter paced by ce1us,
// handed out round-robin, with a one-cycle done pulse to the owner.
module us_delay_sched
  import us_delay_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce1us,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*DW-1:0] delay,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [DW-1:0]     remaining
);

  localparam int IW = $clog2(NREQ);

  state_t          state;
  state_t          state_n;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   owner_n;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   ptr_n;
  logic [DW-1:0]   cnt;
  logic [DW-1:0]   cnt_n;

  logic            pick_v;
  logic [IW-1:0]   pick;
  logic [DW-1:0]   pick_dly;
  logic [IW-1:0]   owner_inc;
  logic [NREQ-1:0] own_oh;

  rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_v),
    .idx   (pick)
  );

  assign pick_dly  = delay[int'(pick)*DW +: DW];
  assign owner_inc = (owner == IW'(NREQ - 1)) ? '0
                   : owner + 1'b1;
  assign own_oh    = NREQ'(1) << owner;

  // State, owner, priority pointer and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      owner <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state: arbitrate in IDLE, count ticks, release after DONE.
  always_comb begin
    state_n = state;
    owner_n = owner;
    ptr_n   = ptr;
    cnt_n   = cnt;
    unique case (state)
      ST_IDLE: begin
        if (pick_v) begin
          owner_n = pick;
          cnt_n   = pick_dly;
          state_n = (pick_dly == '0) ? ST_DONE
                  : ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (!req[owner]) begin
          state_n = ST_IDLE;
          ptr_n   = owner_inc;
        end else if (ce1us) begin
          if (cnt == DW'(1)) begin
            cnt_n   = '0;
            state_n = ST_DONE;
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        ptr_n   = owner_inc;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Outputs come from registers only; no req-to-gnt path.
  always_comb begin
    gnt       = '0;
    done      = '0;
    busy      = 1'b0;
    remaining = '0;
    if (state != ST_IDLE) begin
      gnt       = own_oh;
      busy      = 1'b1;
      remaining = cnt;
    end
    if (state == ST_DONE) begin
      done = own_oh;
    end
  end

endmodule

// File: tb/tb_us_delay_sched.sv
// Bench for us_delay_sched: directed scenarios plus random traffic,
// all compared cycle by cycle against a behavioural model.
module tb_us_delay_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce1us;
  logic [3:0]  req;
  logic [63:0] delay;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        busy;
  logic [15:0] remaining;

  int n_chk  = 0;
  int n_pass = 0;
  int phase  = 0;

  int m_own  = -1;
  int m_cnt  = 0;
  int m_ptr  = 0;
  bit m_done = 1'b0;

  us_delay_sched #(
    .NREQ (4),
    .DW   (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ce1us     (ce1us),
    .req       (req),
    .delay     (delay),
    .gnt       (gnt),
    .done      (done),
    .busy      (busy),
    .remaining (remaining)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: who owns the timer, how many ticks are left.
  task automatic model_step();
    bit found;
    if (rst) begin
      m_own = -1; m_cnt = 0; m_ptr = 0; m_done = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
      m_ptr  = (m_own + 1) % 4;
      m_own  = -1;
    end else if (m_own >= 0) begin
      if (!req[m_own]) begin
        m_ptr = (m_own + 1) % 4;
        m_own = -1;
      end else if (ce1us) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) m_done = 1'b1;
      end
    end else begin
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
        int j;
        j = (m_ptr + k) % 4;
        if (!found && req[j]) begin
          found  = 1'b1;
          m_own  = j;
          m_cnt  = int'(delay[j*16 +: 16]);
          m_done = (m_cnt == 0);
        end
      end
    end
  endtask

  task automatic cycle();
    logic [3:0]  e_gnt;
    logic [3:0]  e_done;
    logic [15:0] e_rem;
    ce1us = (phase == 4);
    @(posedge clk);
    model_step();
    phase = (phase == 4) ? 0 : phase + 1;
    #1;
    e_gnt  = (m_own >= 0) ? (4'b0001 << m_own) : 4'b0000;
    e_done = m_done ? e_gnt : 4'b0000;
    e_rem  = (m_own >= 0) ? 16'(m_cnt) : 16'd0;
    chk("gnt", gnt, e_gnt);
    chk("done", done, e_done);
    chk("busy", busy, m_own >= 0);
    chk("remaining", remaining, e_rem);
  endtask

  task automatic settle();
    req = 4'b0000;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (!busy) break;
    end
    chk("settle_idle", busy, 1'b0);
  endtask

  function automatic int oh2i(input logic [3:0] v);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  initial begin
    int          order[$];
    int          rr_exp[5];
    int          dcnt;
    logic [3:0]  prev_gnt;
    logic [3:0]  remark;
    logic [15:0] rem_q[$];
    logic [3:0]  dacc;
    bit          seen;
    int          ticks;

    rst   = 1'b1;
    req   = 4'hF;
    ce1us = 1'b0;
    delay = {16'd2, 16'd2, 16'd2, 16'd2};

    // Reset held with every request up.
    repeat (3) cycle();
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_rem", remaining, 16'd0);

    // Fairness: all requesting, each drops on done, re-raises next cycle.
    rst      = 1'b0;
    prev_gnt = 4'b0000;
    remark   = 4'b0000;
    dcnt     = 0;
    for (int it = 0; it < 400 && order.size() < 5; it++) begin
      cycle();
      if (it == 0) chk("first_gnt", gnt, 4'b0001);
      if (gnt != 4'b0000 && prev_gnt == 4'b0000) begin
        order.push_back(oh2i(gnt));
        dcnt = 0;
      end
      if (done != 4'b0000) dcnt++;
      if (gnt == 4'b0000 && prev_gnt != 4'b0000)
        chk("one_done_per_grant", 32'(dcnt), 32'd1);
      prev_gnt = gnt;
      req    = req | remark;
      remark = done;
      req    = req & ~done;
    end
    rr_exp = '{0, 1, 2, 3, 0};
    chk("rr_grants", 32'(order.size()), 32'd5);
    for (int i = 0; i < order.size() && i < 5; i++)
      chk("rr_order", 32'(order[i]), 32'(rr_exp[i]));
    settle();

    // Channel 2, delay 3: remaining steps 3,2,1,0.
    delay[2*16 +: 16] = 16'd3;
    req  = 4'b0100;
    seen = 1'b0;
    for (int it = 0; it < 100 && !seen; it++) begin
      cycle();
      if (gnt != 4'b0000 &&
          (rem_q.size() == 0 || rem_q[$] != remaining))
        rem_q.push_back(remaining);
      if (done != 4'b0000) begin
        seen = 1'b1;
        chk("d3_done", done, 4'b0100);
        chk("d3_gnt", gnt, 4'b0100);
        req = 4'b0000;
        cycle();
        chk("d3_busy_after", busy, 1'b0);
      end
    end
    chk("d3_seen", seen, 1'b1);
    chk("d3_steps", 32'(rem_q.size()), 32'd4);
    for (int i = 0; i < rem_q.size() && i < 4; i++)
      chk("d3_rem", rem_q[i], 16'(3 - i));
    settle();

    // Channel 1, delay 0: grant and done together.
    delay[1*16 +: 16] = 16'd0;
    req = 4'b0010;
    cycle();
    chk("z_gnt", gnt, 4'b0010);
    chk("z_done", done, 4'b0010);
    req = 4'b0000;
    cycle();
    chk("z_idle", busy, 1'b0);
    settle();

    // Abort: channel 0 drops after 2 ticks, channel 3 waiting.
    delay[0*16 +: 16] = 16'd5;
    delay[3*16 +: 16] = 16'd1;
    req = 4'b0001;
    cycle();
    chk("ab_gnt0", gnt, 4'b0001);
    req   = 4'b1001;
    ticks = 0;
    dacc  = 4'b0000;
    for (int it = 0; it < 60 && ticks < 2; it++) begin
      cycle();
      dacc = dacc | done;
      if (ce1us) ticks++;
    end
    chk("ab_ticks", 32'(ticks), 32'd2);
    req = 4'b1000;
    cycle();
    dacc = dacc | done;
    chk("ab_idle", gnt, 4'b0000);
    chk("ab_ptr", 32'(dut.ptr), 32'd1);
    cycle();
    chk("ab_gnt3", gnt, 4'b1000);
    chk("ab_no_done0", dacc[0], 1'b0);
    for (int it = 0; it < 40 && done == 4'b0000; it++) cycle();
    chk("ab_done3", done, 4'b1000);
    settle();

    // Reset mid-count kills the timer silently.
    delay[1*16 +: 16] = 16'd100;
    req = 4'b0010;
    repeat (20) cycle();
    chk("mr_busy", busy, 1'b1);
    rst = 1'b1;
    req = 4'b0000;
    cycle();
    chk("mr_gnt", gnt, 4'b0000);
    chk("mr_done", done, 4'b0000);
    chk("mr_rem", remaining, 16'd0);
    rst = 1'b0;
    cycle();

    // Random traffic against the model.
    for (int it = 0; it < 3000; it++) begin
      cycle();
      rst = ($urandom_range(0, 499) == 0);
      for (int i = 0; i < 4; i++) begin
        if (done[i]) begin
          if ($urandom_range(0, 3) != 0) req[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(0, 7) == 0) begin
            req[i] = 1'b1;
            delay[i*16 +: 16] = 16'($urandom_range(0, 6));
          end
        end else if (gnt[i] && $urandom_range(0, 39) == 0) begin
          req[i] = 1'b0;
        end
        if ($urandom_range(0, 15) == 0)
          delay[i*16 +: 16] = 16'($urandom_range(0, 6));
      end
    end
    rst = 1'b0;
    settle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
